// File: rtl/input_debounce_filter.sv
// -----------------------------------------------------------------------------
// input_debounce_filter
//
// Debounces an already-synchronised input level and measures high-pulse width.
// A change on i_sync is only accepted once it has been seen on K+1 consecutive
// samples (K = cfg_stable_cnt); shorter excursions are rejected as glitches.
// Every accepted transition produces a one-cycle rise/fall strobe, and every
// accepted fall publishes the length of the preceding high pulse.
//
// There is no valid/ready handshake: every output is a registered level or a
// one-cycle strobe, presented to the downstream register/interrupt logic
// without back-pressure.
//
// Parameters
//   CNT_W            width of qualification/width counters and K (4..32)
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   i_sync           synchronised input level
//   cfg_en           block enable; 0 freezes level/width, aborts qualification
//   cfg_stable_cnt   qualification count K
//   o_level          debounced level
//   o_rise, o_fall   one-cycle strobes on committed 0->1 / 1->0 transitions
//   o_width          length of the last high pulse in cycles (saturating)
//   o_width_vld      one-cycle strobe: o_width/o_width_ovf updated this cycle
//   o_width_ovf      last high pulse saturated the width counter
//   dbg_state        FSM state (0 = STABLE, 1 = QUALIFY)
//   dbg_qcnt         qualification counter
// -----------------------------------------------------------------------------
module input_debounce_filter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sync,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_stable_cnt,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_width,
  output logic             o_width_vld,
  output logic             o_width_ovf,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_qcnt
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             width_vld_q, width_vld_d;
  logic             width_ovf_q, width_ovf_d;
  logic             commit;
  logic             differs;

  assign differs = (i_sync != level_q);

  // Next-state logic: FSM, qualification counter, commit
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    commit  = 1'b0;

    if (!cfg_en) begin
      // Disabled: abandon any qualification so re-enable starts from zero.
      state_d = ST_STABLE;
      qcnt_d  = '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (!differs) begin
            qcnt_d = '0;
          end else if (cfg_stable_cnt == '0) begin
            commit = 1'b1;
          end else begin
            state_d = ST_QUALIFY;
            qcnt_d  = CNT_ONE;
          end
        end
        ST_QUALIFY: begin
          if (!differs) begin
            state_d = ST_STABLE;
            qcnt_d  = '0;
          end else if (qcnt_q >= cfg_stable_cnt) begin
            // >= so that lowering K mid-qualification commits right away.
            commit = 1'b1;
          end else begin
            qcnt_d = qcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          qcnt_d  = '0;
        end
      endcase

      if (commit) begin
        state_d = ST_STABLE;
        qcnt_d  = '0;
      end
    end
  end

  // Level, strobes and width measurement
  always_comb begin
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    wcnt_d      = wcnt_q;
    width_d     = width_q;
    width_vld_d = 1'b0;
    width_ovf_d = width_ovf_q;

    // Width counts enabled cycles spent high; saturates instead of wrapping.
    if (cfg_en && level_q && (wcnt_q != CNT_MAX)) begin
      wcnt_d = wcnt_q + CNT_ONE;
    end

    if (commit) begin
      level_d = ~level_q;
      if (!level_q) begin
        rise_d = 1'b1;
        wcnt_d = CNT_ONE;
      end else begin
        fall_d      = 1'b1;
        width_d     = wcnt_q;
        width_ovf_d = (wcnt_q == CNT_MAX);
        width_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STABLE;
      qcnt_q      <= '0;
      wcnt_q      <= '0;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      width_q     <= '0;
      width_vld_q <= 1'b0;
      width_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      wcnt_q      <= wcnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      width_q     <= width_d;
      width_vld_q <= width_vld_d;
      width_ovf_q <= width_ovf_d;
    end
  end

  assign o_level     = level_q;
  assign o_rise      = rise_q;
  assign o_fall      = fall_q;
  assign o_width     = width_q;
  assign o_width_vld = width_vld_q;
  assign o_width_ovf = width_ovf_q;
  assign dbg_state   = state_q;
  assign dbg_qcnt    = qcnt_q;

endmodule

// File: tb/tb_input_debounce_filter.sv
// -----------------------------------------------------------------------------
// tb_input_debounce_filter
//
// Drives a 16-bit and a 4-bit instance from the same stimulus. A reference
// model counts consecutive differing samples and flips the level once that
// run exceeds K; the high pulse is measured as an unbounded count of enabled
// high cycles, clipped to the counter maximum when reported.
// -----------------------------------------------------------------------------
module tb_input_debounce_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sync = 1'b0;
  logic        cfg_en = 1'b1;
  logic [15:0] cfg_stable_cnt = 16'd0;
  logic [3:0]  cfg_stable_cnt4;

  logic        level16, rise16, fall16, vld16, ovf16, st16;
  logic [15:0] width16, qcnt16;
  logic        level4, rise4, fall4, vld4, ovf4, st4;
  logic [3:0]  width4, qcnt4;

  int errors = 0;
  int checks = 0;

  assign cfg_stable_cnt4 = cfg_stable_cnt[3:0];

  always #5 clk = ~clk;

  input_debounce_filter #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .i_sync(i_sync), .cfg_en(cfg_en),
    .cfg_stable_cnt(cfg_stable_cnt),
    .o_level(level16), .o_rise(rise16), .o_fall(fall16),
    .o_width(width16), .o_width_vld(vld16), .o_width_ovf(ovf16),
    .dbg_state(st16), .dbg_qcnt(qcnt16)
  );

  input_debounce_filter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_sync(i_sync), .cfg_en(cfg_en),
    .cfg_stable_cnt(cfg_stable_cnt4),
    .o_level(level4), .o_rise(rise4), .o_fall(fall4),
    .o_width(width4), .o_width_vld(vld4), .o_width_ovf(ovf4),
    .dbg_state(st4), .dbg_qcnt(qcnt4)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    bit level;
    int run;    // consecutive enabled samples differing from level
    int wc;     // enabled cycles spent high in the current pulse
    bit rise;
    bit fall;
    bit vld;
    bit ovf;
    int width;
  } m_t;

  m_t m16 = '0;
  m_t m4  = '0;

  function automatic m_t step(m_t s, bit r, bit en, bit d, int k, int maxv);
    m_t n;
    n = s;
    n.rise = 1'b0;
    n.fall = 1'b0;
    n.vld  = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (!en) begin
      n.run = 0;
      return n;
    end
    if (s.level) n.wc = s.wc + 1;
    if (d == s.level) begin
      n.run = 0;
    end else if (s.run + 1 > k) begin
      n.run   = 0;
      n.level = ~s.level;
      if (!s.level) begin
        n.rise = 1'b1;
        n.wc   = 1;
      end else begin
        n.fall  = 1'b1;
        n.vld   = 1'b1;
        n.width = (s.wc > maxv) ? maxv : s.wc;
        n.ovf   = (s.wc >= maxv);
      end
    end else begin
      n.run = s.run + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m16 <= step(m16, rst, cfg_en, i_sync, int'(cfg_stable_cnt), 65535);
    m4  <= step(m4, rst, cfg_en, i_sync, int'(cfg_stable_cnt4), 15);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("m16_level", int'(level16), int'(m16.level));
    check("m16_rise",  int'(rise16),  int'(m16.rise));
    check("m16_fall",  int'(fall16),  int'(m16.fall));
    check("m16_vld",   int'(vld16),   int'(m16.vld));
    check("m16_ovf",   int'(ovf16),   int'(m16.ovf));
    check("m16_width", int'(width16), m16.width);
    check("m16_qcnt",  int'(qcnt16),  m16.run);
    check("m16_state", int'(st16),    int'(m16.run != 0));
    check("m4_level",  int'(level4),  int'(m4.level));
    check("m4_rise",   int'(rise4),   int'(m4.rise));
    check("m4_fall",   int'(fall4),   int'(m4.fall));
    check("m4_vld",    int'(vld4),    int'(m4.vld));
    check("m4_ovf",    int'(ovf4),    int'(m4.ovf));
    check("m4_width",  int'(width4),  m4.width);
    check("m4_qcnt",   int'(qcnt4),   m4.run);
    check("m4_state",  int'(st4),     int'(m4.run != 0));
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int hold;

  initial begin
    rst = 1'b1;
    tick(2);
    check("rst_level", int'(level16), 0);
    check("rst_width", int'(width16), 0);
    check("rst_vld",   int'(vld16),   0);
    rst = 1'b0;
    cfg_en = 1'b1;

    // K = 3: level changes on the 4th edge after the input change
    cfg_stable_cnt = 16'd3;
    tick(2);
    i_sync = 1'b1;
    tick(3);
    check("k3_level_before", int'(level16), 0);
    check("k3_qcnt_before",  int'(qcnt16),  3);
    tick(1);
    check("k3_level_edge4", int'(level16), 1);
    check("k3_rise_edge4",  int'(rise16),  1);
    tick(1);
    check("k3_rise_once", int'(rise16), 0);
    tick(5);
    i_sync = 1'b0;
    tick(6);
    check("k3_fall_done", int'(level16), 0);

    // Glitches of 1 and 3 cycles are rejected
    i_sync = 1'b1;
    tick(1);
    i_sync = 1'b0;
    tick(1);
    check("glitch1_qcnt", int'(qcnt16), 0);
    i_sync = 1'b1;
    tick(3);
    check("glitch3_qcnt_peak", int'(qcnt16), 3);
    i_sync = 1'b0;
    tick(1);
    check("glitch3_qcnt", int'(qcnt16), 0);
    check("glitch3_level", int'(level16), 0);
    tick(2);

    // K = 0: 5-cycle pulse gives width 5
    cfg_stable_cnt = 16'd0;
    i_sync = 1'b1;
    tick(5);
    i_sync = 1'b0;
    tick(1);
    check("k0_vld",   int'(vld16),   1);
    check("k0_width", int'(width16), 5);
    check("k0_ovf",   int'(ovf16),   0);
    tick(1);
    check("k0_vld_once", int'(vld16), 0);
    tick(2);

    // 20-cycle pulse saturates the 4-bit counter
    i_sync = 1'b1;
    tick(20);
    i_sync = 1'b0;
    tick(1);
    check("sat_width4",  int'(width4),  15);
    check("sat_ovf4",    int'(ovf4),    1);
    check("sat_width16", int'(width16), 20);
    check("sat_ovf16",   int'(ovf16),   0);
    tick(2);

    // Lower K from 8 to 2 with qcnt = 5
    cfg_stable_cnt = 16'd8;
    i_sync = 1'b1;
    tick(5);
    check("klow_qcnt5",  int'(qcnt16),  5);
    check("klow_level0", int'(level16), 0);
    cfg_stable_cnt = 16'd2;
    tick(1);
    check("klow_commit", int'(level16), 1);
    check("klow_rise",   int'(rise16),  1);

    // Disable mid-qualification
    cfg_stable_cnt = 16'd4;
    i_sync = 1'b0;
    tick(2);
    cfg_en = 1'b0;
    tick(1);
    check("dis_qcnt",  int'(qcnt16),  0);
    tick(6);
    check("dis_level_hold", int'(level16), 1);
    cfg_en = 1'b1;
    tick(4);
    check("reen_not_yet", int'(level16), 1);
    tick(1);
    check("reen_commit", int'(level16), 0);
    tick(2);

    // Reset with level high and a fall qualification pending
    cfg_stable_cnt = 16'd3;
    i_sync = 1'b1;
    tick(4);
    check("pre_rst_level", int'(level16), 1);
    i_sync = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_mid_level", int'(level16), 0);
    check("rst_mid_fall",  int'(fall16),  0);
    check("rst_mid_vld",   int'(vld16),   0);
    check("rst_mid_qcnt",  int'(qcnt16),  0);
    rst = 1'b0;
    tick(2);

    // Randomized phase
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        i_sync = ~i_sync;
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 199) == 0) cfg_stable_cnt = 16'($urandom_range(0, 5));
      cfg_en = ($urandom_range(0, 24) != 0);
      rst    = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debounce_filter.md
# input_debounce_filter

Debounce and pulse-width measurement stage placed directly downstream of the metastability filter on every external GPIO/sensor input. It takes the already-synchronised level, rejects glitches shorter than a programmable qualification time, and publishes a clean level. It also emits single-cycle rise and fall strobes and measures the high-pulse width in clock cycles for the register and interrupt logic that follows.

## Interface
- `CNT_W`, 16: width of the qualification counter, the width counter and `cfg_stable_cnt`; legal range 4..32.
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_sync`  in  1  synchronised input from the metastability filter.
- `cfg_en`  in  1  block enable.
- `cfg_stable_cnt`  in  CNT_W  qualification count K.
- `o_level`  out  1  debounced level.
- `o_rise`  out  1  one-cycle strobe on a committed 0->1 transition.
- `o_fall`  out  1  one-cycle strobe on a committed 1->0 transition.
- `o_width`  out  CNT_W  length of the last high pulse, in cycles.
- `o_width_vld`  out  1  one-cycle strobe; `o_width` and `o_width_ovf` were updated this cycle.
- `o_width_ovf`  out  1  the last high pulse saturated the width counter.

## Operation
- FSM with two states: STABLE and QUALIFY. The qualification counter `qcnt` is CNT_W bits wide.
- STABLE:
  - `i_sync == o_level`: stay in STABLE; `qcnt` = 0.
  - `i_sync != o_level` and K == 0: commit immediately.
  - `i_sync != o_level` and K != 0: go to QUALIFY; `qcnt` = 1.
- QUALIFY:
  - `i_sync == o_level`: glitch rejected. Return to STABLE, `qcnt` = 0, no strobe.
  - `i_sync != o_level` and `qcnt >= K`: commit.
  - Otherwise increment `qcnt`.
  - The comparison uses `>=`, so lowering K mid-qualification commits on the next differing sample.
- Commit, all at one clock edge:
  - `o_level` toggles.
  - `o_rise` or `o_fall` asserts for that cycle only.
  - FSM returns to STABLE and `qcnt` = 0.
- Net effect: the level flips on the (K+1)-th consecutive differing sample.
- Width counter `wcnt` (CNT_W bits):
  - Loaded with 1 on a rise commit.
  - Increments every cycle while `o_level` = 1.
  - Saturates at all-ones and never wraps.
- Fall commit:
  - `o_width` <= `wcnt`.
  - `o_width_ovf` <= (`wcnt` == all-ones).
  - `o_width_vld` = 1 for one cycle.
  - `o_width` and `o_width_ovf` hold until the next fall commit.
- `cfg_en` = 0:
  - FSM forced to STABLE, `qcnt` = 0, no strobes.
  - `o_level`, `wcnt` and the width outputs hold.
  - When re-enabled, qualification restarts from zero.
- Commits are mutually exclusive, so `o_rise` and `o_fall` are never high together.

## Timing
- Reset value of every output is 0; FSM in STABLE; `qcnt` = `wcnt` = 0.
- Reset has priority over `cfg_en` and over any pending qualification. A pulse in progress is discarded with no `o_width_vld`.
- Latency from the first differing `i_sync` sample to the `o_level` change: K+1 clock edges (1 edge when K = 0).
- The strobes are registered and coincident with the `o_level` change.
- `o_width` equals the number of cycles `o_level` was 1, which is the fall-commit edge minus the rise-commit edge.
- Minimum spacing between strobes is 1 cycle when K = 0, and K+1 cycles otherwise.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset then K = 3, `i_sync` 0->1 held 10 cycles -> `o_level` and `o_rise` change at the 4th edge after the input change. `o_rise` is high exactly 1 cycle.
- K = 3, `i_sync` 1-cycle and 3-cycle high glitches -> no `o_level` change and no strobes. `qcnt` returns to 0 after each glitch.
- K = 0, `i_sync` high for 5 cycles then low -> `o_level` follows with 1-cycle latency. `o_width` = 5 with `o_width_vld` for 1 cycle; `o_width_ovf` = 0.
- CNT_W = 4, K = 0, `i_sync` high for 20 cycles -> `o_width` = 15 and `o_width_ovf` = 1.
- K = 8, lower K to 2 while in QUALIFY with `qcnt` = 5 -> commit at the next edge. Then deassert `cfg_en` mid-qualification -> no commit, and `o_level` holds.
- Assert `rst` while `o_level` = 1 and a qualification is pending -> all outputs are 0 on the next cycle with no `o_fall` or `o_width_vld` strobe.
